instr_ram_banked_ctrl: RTL and testbench

// - Parametrised instruction RAM controller: successor of the single-bank core instruction RAM wrapper.
// - Splits RAM_SIZE bytes into NUM_BANKS word-interleaved banks behind a req/gnt/rvalid port.
// - Adds a post-reset clear FSM, boot bypass write blocking and per-bank activity gating.
// - Sits between the core instruction interface / AXI-to-mem bridge and the bank storage.

---
 rtl/instr_ram_banked_ctrl.sv | 124 ++++++++++++
 tb/tb_instr_ram_banked_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/instr_ram_banked_ctrl.sv
// instr_ram_banked_ctrl: word-interleaved banked instruction RAM with post-reset clear and bypass write blocking.
// Define INSTR_RAM_PARITY_EN to store per-byte even parity and flag mismatches on reads.
module instr_ram_banked_ctrl #(
    parameter int RAM_SIZE       = 32768,
    parameter int NUM_BANKS      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = $clog2(RAM_SIZE),
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_WORD = '0
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    input  logic                    bypass_en_i,
    output logic                    init_done_o
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(NB);
    localparam int LB    = $clog2(NUM_BANKS);
    localparam int BW    = LB > 0 ? LB : 1;
    localparam int DEPTH = RAM_SIZE / NB / NUM_BANKS;
    localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int WAW   = ADDR_WIDTH - OFF;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                          state, state_n;
    logic [IW-1:0]                   idx, idx_n, row, mem_a;
    logic [BW-1:0]                   bank, sel_q;
    logic [WAW-1:0]                  word_addr;
    logic                            clearing, mem_we, mem_re, rd_q, unused;
    logic [NB-1:0]                   mem_be;
    logic [DATA_WIDTH-1:0]           mem_wd;
    logic [NUM_BANKS*DATA_WIDTH-1:0] rd_all;

    assign word_addr = addr_i[ADDR_WIDTH-1:OFF];
    assign row       = IW'(word_addr >> LB);
    assign bank      = NUM_BANKS > 1 ? BW'(word_addr) : '0;
    assign unused    = ^{addr_i & ADDR_WIDTH'(NB - 1), rd_q};
    assign clearing  = state == CLEAR;
    assign gnt_o     = req_i & init_done_o;
    // The clear sweep drives every bank at the same row with full byte enables.
    assign mem_we    = clearing | (gnt_o & we_i & ~bypass_en_i);
    assign mem_re    = gnt_o & ~we_i;
    assign mem_a     = clearing ? idx : row;
    assign mem_be    = clearing ? '1 : be_i;
    assign mem_wd    = clearing ? CLEAR_WORD : wdata_i;
    assign rdata_o   = rd_all[sel_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_n = (clearing && idx == IW'(DEPTH - 1)) ? READY : state;
        idx_n   = clearing ? idx + 1'b1 : idx;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state       <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
            idx         <= '0;
            init_done_o <= 1'b0;
            rvalid_o    <= 1'b0;
            rd_q        <= 1'b0;
            sel_q       <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            init_done_o <= state_n == READY;
            rvalid_o    <= gnt_o;
            rd_q        <= mem_re;
            if (mem_re) sel_q <= bank;
        end
    end

`ifdef INSTR_RAM_PARITY_EN
    logic [NUM_BANKS-1:0] err_all;

    function automatic logic [NB-1:0] parity(input logic [DATA_WIDTH-1:0] d);
        for (int i = 0; i < NB; i++) parity[i] = ^d[8*i +: 8];
    endfunction

    assign err_o = rvalid_o & rd_q & err_all[sel_q];
`else
    assign err_o = 1'b0;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] rd;
        logic                  en;
        // Only the addressed bank toggles; the rest stay disabled.
        assign en = clearing | (gnt_o & (bank == BW'(b)));
        assign rd_all[b*DATA_WIDTH +: DATA_WIDTH] = rd;
        always_ff @(posedge clk) begin
            if (en & mem_we)
                for (int i = 0; i < NB; i++)
                    if (mem_be[i]) mem[mem_a][8*i +: 8] <= mem_wd[8*i +: 8];
        end
        always_ff @(posedge clk or posedge rst_i) begin
            if (rst_i) rd <= '0;
            else if (en & mem_re) rd <= mem[mem_a];
        end
`ifdef INSTR_RAM_PARITY_EN
        logic [NB-1:0] par_mem [DEPTH];
        logic          err;
        assign err_all[b] = err;
        always_ff @(posedge clk) begin
            if (en & mem_we)
                for (int i = 0; i < NB; i++)
                    if (mem_be[i]) par_mem[mem_a][i] <= ^mem_wd[8*i +: 8];
        end
        always_ff @(posedge clk or posedge rst_i) begin
            if (rst_i) err <= 1'b0;
            else if (en & mem_re) err <= |((parity(mem[mem_a]) ^ par_mem[mem_a]) & be_i);
        end
`endif
    end
endmodule

// File: tb/tb_instr_ram_banked_ctrl.sv
// tb_instr_ram_banked_ctrl: vector table plus reset/clear sequences, responses checked against an in-order scoreboard.
module tb_instr_ram_banked_ctrl;
    logic        clk = 1'b0, rst_i = 1'b1, req_i = 1'b0, we_i = 1'b0, bypass_en_i = 1'b0;
    logic [14:0] addr_i = '0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic        gnt_o, rvalid_o, err_o, init_done_o;
    logic [31:0] rdata_o;

    int checks = 0, errors = 0;

    typedef struct {logic [31:0] rdata; logic err;} exp_t;
    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        byp;
        logic [31:0] exp;
        logic        perr;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[$];
    logic [31:0] last_rd = '0;

    instr_ram_banked_ctrl dut (
        .clk(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .bypass_en_i(bypass_en_i), .init_done_o(init_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t rd(input logic [14:0] a, input logic [31:0] e, input logic pe = 1'b0);
        rd = '{1'b0, a, 4'hF, 32'h0, 1'b0, e, pe};
    endfunction

    function automatic vec_t wr(input logic [14:0] a, input logic [31:0] d, input logic [3:0] be,
                                input logic byp = 1'b0);
        wr = '{1'b1, a, be, d, byp, 32'h0, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (rvalid_o === 1'b1) begin
            if (sb.size() == 0) check("spurious_rvalid", 1, 0);
            else begin
                mon_e = sb.pop_front();
                check("rsp_rdata", rdata_o, mon_e.rdata);
                check("rsp_err", {31'b0, err_o}, {31'b0, mon_e.err});
            end
        end
    end

    task automatic access(input vec_t v);
        @(negedge clk);
        req_i = 1'b1; we_i = v.we; addr_i = v.addr; be_i = v.be; wdata_i = v.wdata; bypass_en_i = v.byp;
        #1 check("gnt", {31'b0, gnt_o}, 1);
        if (!v.we) last_rd = v.exp;
        sb.push_back('{v.we ? last_rd : v.exp, v.we ? 1'b0 : v.perr});
    endtask

    task automatic drain();
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0; bypass_en_i = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
    endtask

    // Holds a read request through the sweep, so any early grant is caught.
    task automatic wait_init();
        int bad = 0;
        for (int k = 1; k <= 2048; k++) begin
            @(posedge clk);
            #1;
            if (k < 2048 && gnt_o !== 1'b0) bad++;
            if (k == 2047) check("init_done_early", {31'b0, init_done_o}, 0);
        end
        check("init_done_at_2048", {31'b0, init_done_o}, 1);
        check("gnt_during_clear", bad, 0);
    endtask

    initial begin
        vecs.push_back(rd(15'h100, 32'h0000_0000));
        vecs.push_back(wr(15'h040, 32'hDEAD_BEEF, 4'b0101));
        vecs.push_back(rd(15'h040, 32'h00AD_00EF));
        vecs.push_back(wr(15'h000, 32'h1111_1111, 4'hF));
        vecs.push_back(wr(15'h004, 32'h2222_2222, 4'hF));
        vecs.push_back(wr(15'h008, 32'h3333_3333, 4'hF));
        vecs.push_back(wr(15'h00C, 32'h4444_4444, 4'hF));
        vecs.push_back(rd(15'h000, 32'h1111_1111));
        vecs.push_back(rd(15'h004, 32'h2222_2222));
        vecs.push_back(rd(15'h008, 32'h3333_3333));
        vecs.push_back(rd(15'h00C, 32'h4444_4444));
        vecs.push_back(wr(15'h010, 32'h1234_5678, 4'hF, 1'b1));
        vecs.push_back(rd(15'h010, 32'h0000_0000));
        vecs.push_back(wr(15'h000, 32'hAABB_CCDD, 4'h0));
        vecs.push_back(rd(15'h000, 32'h1111_1111));
        vecs.push_back(wr(15'h004, 32'h5566_7788, 4'b1010));
        vecs.push_back(rd(15'h004, 32'h5522_7722));
        vecs.push_back(wr(15'h7FFC, 32'hCAFE_F00D, 4'hF));
        vecs.push_back(rd(15'h7FFC, 32'hCAFE_F00D));
        vecs.push_back(rd(15'h00B, 32'h3333_3333));
        vecs.push_back(rd(15'h040, 32'h00AD_00EF));
        vecs.push_back(wr(15'h014, 32'h6666_6666, 4'hF));
        vecs.push_back(rd(15'h004, 32'h5522_7722));
        vecs.push_back(rd(15'h014, 32'h6666_6666));

        req_i = 1'b1; addr_i = 15'h100; be_i = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_gnt", {31'b0, gnt_o}, 0);
        check("rst_rvalid", {31'b0, rvalid_o}, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_err", {31'b0, err_o}, 0);
        check("rst_init_done", {31'b0, init_done_o}, 0);
        rst_i = 1'b0;
        wait_init();

        foreach (vecs[i]) access(vecs[i]);
        drain();

`ifdef INSTR_RAM_PARITY_EN
        force dut.g_bank[1].par_mem[1][0] = 1'b1;
        access(rd(15'h014, 32'h6666_6666, 1'b1));
        drain();
        release dut.g_bank[1].par_mem[1][0];
`endif

        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 15'h040; be_i = 4'hF;
        rst_i = 1'b1;
        #1;
        check("rst2_rdata", rdata_o, 0);
        check("rst2_init_done", {31'b0, init_done_o}, 0);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        #1 check("midclear_rst_init_done", {31'b0, init_done_o}, 0);
        @(negedge clk);
        rst_i = 1'b0;
        wait_init();
        access(rd(15'h040, 32'h0000_0000));
        access(rd(15'h7FFC, 32'h0000_0000));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
